// File: rtl/tx_payload_fifo_if.sv
// rtl/tx_payload_fifo_if.sv - write-side and stream-side signals of the TX payload FIFO.
// The FIFO is the slave; the host/encapsulator pair is the master.
interface tx_payload_fifo_if #(
    parameter int ADDR_W = 11
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              wr_last;
    logic              wr_ready;
    logic              wr_err;
    logic              buffer_ready;
    logic              data_recive;
    logic              read_en;
    logic [7:0]        data_in;
    logic              buffer_empt;
    logic [ADDR_W:0]   frame_cnt;

    modport master (
        output wr_en, wr_data, wr_last, data_recive,
        input  wr_ready, wr_err, buffer_ready, read_en, data_in, buffer_empt, frame_cnt
    );

    modport slave (
        input  wr_en, wr_data, wr_last, data_recive,
        output wr_ready, wr_err, buffer_ready, read_en, data_in, buffer_empt, frame_cnt
    );
endinterface

// File: rtl/tx_payload_fifo.sv
// rtl/tx_payload_fifo.sv - frame-aware store-and-forward byte FIFO feeding the TX encapsulator.
// Whole frames are committed on wr_last; overflowing or over-long frames are rolled back.
module tx_payload_fifo #(
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = 1500
) (
    input  logic               clk,
    input  logic               rst,
    tx_payload_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int LEN_W = $clog2(MAX_LEN + 2);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} rd_state_t;

    logic [8:0]        mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] frame_start_q, frame_start_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  used_cnt_q, used_cnt_d;
    logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
    logic              discard_q, discard_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    rd_state_t         state_q, state_d;
    logic              rd_last_q, rd_last_d;
    logic              read_en_q, read_en_d;
    logic [7:0]        data_in_q, data_in_d;
    logic              wr_ready_q, wr_ready_d;
    logic              wr_err_q, wr_err_d;
    logic              buffer_ready_q, buffer_ready_d;
    logic              buffer_empt_q, buffer_empt_d;

    logic              full;
    logic              wr_acc;
    logic              commit;
    logic              drop;
    logic              rd_fetch;
    logic [8:0]        rd_word;
    logic [CNT_W-1:0]  drop_sub;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        frame_start_d = frame_start_q;
        rd_ptr_d      = rd_ptr_q;
        len_cnt_d     = len_cnt_q;
        discard_d     = discard_q;
        state_d       = state_q;
        rd_last_d     = rd_last_q;
        read_en_d     = read_en_q;
        data_in_d     = data_in_q;
        wr_acc        = 1'b0;
        commit        = 1'b0;
        drop          = 1'b0;
        rd_fetch      = 1'b0;
        drop_sub      = '0;
        rd_word       = mem[rd_ptr_q];
        full          = (used_cnt_q == CNT_W'(DEPTH));

        if (bus.wr_en) begin
            if (discard_q) begin
                // Tail of an already-dropped frame: swallow silently until its last byte.
                if (bus.wr_last) begin
                    discard_d = 1'b0;
                end
            end else if (full || (len_cnt_q >= LEN_W'(MAX_LEN))) begin
                drop          = 1'b1;
                drop_sub      = CNT_W'(len_cnt_q);
                wr_ptr_d      = frame_start_q;
                len_cnt_d     = '0;
                discard_d     = !bus.wr_last;
            end else begin
                wr_acc   = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (bus.wr_last) begin
                    commit        = 1'b1;
                    frame_start_d = wr_ptr_q + ADDR_W'(1);
                    len_cnt_d     = '0;
                end else begin
                    len_cnt_d = len_cnt_q + LEN_W'(1);
                end
            end
        end

        case (state_q)
            IDLE: begin
                if ((frame_cnt_q != '0) && bus.data_recive) begin
                    state_d   = STREAM;
                    read_en_d = 1'b1;
                    rd_fetch  = 1'b1;
                end
            end
            STREAM: begin
                if (rd_last_q) begin
                    state_d   = DONE;
                    read_en_d = 1'b0;
                end else begin
                    rd_fetch = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_fetch) begin
            data_in_d = rd_word[7:0];
            rd_last_d = rd_word[8];
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
        end

        used_cnt_d  = used_cnt_q + CNT_W'(wr_acc) - CNT_W'(rd_fetch) - drop_sub;
        frame_cnt_d = frame_cnt_q + CNT_W'(commit) - CNT_W'(state_q == DONE);

        // Flags are computed from next-state values so they line up with frame_cnt.
        wr_ready_d     = (used_cnt_d != CNT_W'(DEPTH));
        wr_err_d       = drop;
        buffer_ready_d = (state_d == IDLE) && (frame_cnt_d != '0);
        buffer_empt_d  = (state_d == DONE) || ((state_d == IDLE) && (frame_cnt_d == '0));
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= {bus.wr_last, bus.wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q       <= '0;
            frame_start_q  <= '0;
            rd_ptr_q       <= '0;
            used_cnt_q     <= '0;
            len_cnt_q      <= '0;
            discard_q      <= 1'b0;
            frame_cnt_q    <= '0;
            state_q        <= IDLE;
            rd_last_q      <= 1'b0;
            read_en_q      <= 1'b0;
            data_in_q      <= '0;
            wr_ready_q     <= 1'b0;
            wr_err_q       <= 1'b0;
            buffer_ready_q <= 1'b0;
            buffer_empt_q  <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            frame_start_q  <= frame_start_d;
            rd_ptr_q       <= rd_ptr_d;
            used_cnt_q     <= used_cnt_d;
            len_cnt_q      <= len_cnt_d;
            discard_q      <= discard_d;
            frame_cnt_q    <= frame_cnt_d;
            state_q        <= state_d;
            rd_last_q      <= rd_last_d;
            read_en_q      <= read_en_d;
            data_in_q      <= data_in_d;
            wr_ready_q     <= wr_ready_d;
            wr_err_q       <= wr_err_d;
            buffer_ready_q <= buffer_ready_d;
            buffer_empt_q  <= buffer_empt_d;
        end
    end

    assign bus.wr_ready     = wr_ready_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.buffer_ready = buffer_ready_q;
    assign bus.read_en      = read_en_q;
    assign bus.data_in      = data_in_q;
    assign bus.buffer_empt  = buffer_empt_q;
    assign bus.frame_cnt    = frame_cnt_q;
endmodule

// File: doc/tx_payload_fifo.md
Name: tx_payload_fifo

Overview:
- Byte-wide, frame-aware store-and-forward FIFO that sits directly upstream of the Ethernet TX encapsulation stage.
- Accepts payload bytes from the host/MAC-client side and commits whole frames only.
- Streams one complete frame to the encapsulator using its handshake: buffer_ready / data_recive / read_en / buffer_empt.
- Drops frames that overflow the store or exceed the maximum payload length.

Parameters:
- ADDR_W, 11, log2 of storage depth; storage = 2**ADDR_W bytes, each with a last-flag bit.
- MAX_LEN, 1500, maximum payload bytes per frame; longer frames are dropped.

Ports:
- clk  in  1  single clock for both sides.
- rst  in  1  asynchronous reset, active-low.
- wr_en  in  1  write strobe; wr_data is valid this cycle.
- wr_data  in  8  payload byte.
- wr_last  in  1  qualifies the last byte of a frame (used only with wr_en).
- wr_ready  out  1  high when at least one byte of free space exists.
- wr_err  out  1  one-cycle pulse when the frame in progress is dropped.
- buffer_ready  out  1  at least one committed frame is waiting and the read FSM is in IDLE.
- data_recive  in  1  downstream request to start streaming (level).
- read_en  out  1  data_in is valid this cycle.
- data_in  out  8  streamed payload byte.
- buffer_empt  out  1  no stream in progress and no data to stream; also pulses at frame end.
- frame_cnt  out  ADDR_W+1  number of committed, unread frames.

Behaviour:
- Reset (rst=0, async): all outputs registered and cleared, except buffer_empt=1.
  - Cleared outputs: wr_ready=0, wr_err=0, buffer_ready=0, read_en=0, data_in=0, frame_cnt=0.
  - Internal reset: wr_ptr, frame_start, rd_ptr, used_cnt and len_cnt=0; read FSM=IDLE.
  - One cycle after reset release, wr_ready=1.
- Reset mid-frame or mid-stream: all state is discarded, nothing is committed, and read_en drops asynchronously.
- Write side:
  - Byte written at wr_ptr when wr_en=1 and the store is not full; wr_ptr and len_cnt increment (modulo 2**ADDR_W).
  - frame_start holds the wr_ptr value at the first byte of the current frame.
  - On wr_en & wr_last with no error: commit the frame. frame_cnt+1, frame_start<=wr_ptr+1, len_cnt<=0.
  - Drop condition A: wr_en while full (used_cnt==2**ADDR_W).
  - Drop condition B: a byte that would make len_cnt > MAX_LEN.
  - On drop: wr_ptr<=frame_start, used_cnt reduced by len_cnt, len_cnt<=0, wr_err=1 for one cycle.
  - After a drop, further bytes up to and including the next wr_last are discarded silently, with no further wr_err.
  - wr_last with len_cnt==0 and wr_en=1 is a valid 1-byte frame.
- used_cnt:
  - +1 per accepted write, -1 per streamed byte.
  - On a simultaneous write and read, used_cnt is unchanged.
  - wr_ready = (used_cnt != 2**ADDR_W), registered.
- Read FSM states:
  - IDLE:
    - buffer_ready = (frame_cnt>0).
    - buffer_empt = (frame_cnt==0).
    - If frame_cnt>0 and data_recive=1 at a clock edge, go to STREAM. On that same edge, register read_en=1 and data_in=mem[rd_ptr].
    - This gives one cycle of latency from data_recive sampled to the first valid byte.
  - STREAM:
    - read_en=1 every cycle; one byte per cycle with no gaps; rd_ptr increments per byte; buffer_ready=0; buffer_empt=0.
    - When the byte presented carries the last flag, go to DONE on the next edge.
  - DONE (one cycle):
    - read_en=0, buffer_empt=1, frame_cnt-1.
    - Then return to IDLE.
- data_recive handling:
  - data_recive is ignored outside IDLE.
  - If it is still high when IDLE is re-entered and another frame is committed, the next frame starts immediately.
  - The consumer must lower data_recive before DONE to avoid this.
- Simultaneous commit and DONE in the same cycle: frame_cnt unchanged.
- A commit in the same cycle as an IDLE start decision: the new frame is not counted until the next cycle.
- Pointer wrap-around is transparent; frames may straddle the end of the store.

Test Plan:
- Reset, then write 4 bytes 0x11,0x22,0x33,0x44 with wr_last on 0x44 -> frame_cnt=1, buffer_ready=1. Pulse data_recive -> next cycle read_en=1 for exactly 4 cycles with data_in 0x11..0x44, then buffer_empt=1 and frame_cnt=0.
- Write a 1501-byte frame -> wr_err pulses on byte 1501, the remaining bytes are ignored, and frame_cnt stays 0. A following 46-byte frame streams correctly.
- ADDR_W=4: write a 10-byte frame, then a 10-byte frame -> wr_ready falls after 16 bytes, the write while full pulses wr_err, and the first frame streams intact.
- Write frame B while frame A is streaming, with wr_last landing on A's DONE cycle -> frame_cnt remains 1, and B streams after the next data_recive.
- Assert rst mid-stream (after 2 of 5 bytes) -> read_en=0 immediately; after release frame_cnt=0, buffer_empt=1, wr_ready=1.
- Write 3 frames that wrap the pointer (ADDR_W=4, lengths 7,7,7, each read before the next write completes) -> all bytes are returned in order.
